// File: rtl/tail_bits_extractor_parallel.sv
// tail_bits_extractor_parallel
// Decoder-side tail stage. It passes the K/8 byte-parallel x/z/z' data beats of
// a code block downstream with one cycle of latency. It then strips the single
// tail beat and unpacks its 12 termination bits into the trellis tails of both
// constituent encoders.
module tail_bits_extractor_parallel #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int CNT_W   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       blk_size_sel,
    input  logic [7:0] xk_in,
    input  logic [7:0] zk_in,
    input  logic [7:0] zk_prime_in,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [7:0] xk_out,
    output logic [7:0] zk_out,
    output logic [7:0] zk_prime_out,
    output logic [2:0] tail_x1,
    output logic [2:0] tail_z1,
    output logic [2:0] tail_x2,
    output logic [2:0] tail_z2,
    output logic       tail_valid,
    output logic       tail_err,
    output logic       proto_err
);

    localparam int NB_SMALL_I = K_SMALL / 8;
    localparam int NB_LARGE_I = K_LARGE / 8;
    localparam logic [CNT_W-1:0] NB_SMALL = NB_SMALL_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] NB_LARGE = NB_LARGE_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // Termination bits are interleaved over the low nibbles of the three lanes;
    // result is {tail_x1, tail_z1, tail_x2, tail_z2}.
    function automatic logic [11:0] unpack_tail(input logic [3:0] x_lo,
                                                input logic [3:0] z_lo,
                                                input logic [3:0] zp_lo);
        logic [2:0] x1;
        logic [2:0] z1;
        logic [2:0] x2;
        logic [2:0] z2;
        x1 = {z_lo[1],  zp_lo[0], x_lo[0]};
        z1 = {zp_lo[1], x_lo[1],  z_lo[0]};
        x2 = {z_lo[3],  zp_lo[2], x_lo[2]};
        z2 = {zp_lo[3], x_lo[3],  z_lo[2]};
        return {x1, z1, x2, z2};
    endfunction

    // The upper nibbles of a tail beat carry nothing and must be zero.
    function automatic logic tail_nibble_err(input logic [3:0] x_hi,
                                             input logic [3:0] z_hi,
                                             input logic [3:0] zp_hi);
        return |{x_hi, z_hi, zp_hi};
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] nbeats_r;
    logic             out_valid_r;
    logic             out_sop_r;
    logic             out_eop_r;
    logic [7:0]       xk_out_r;
    logic [7:0]       zk_out_r;
    logic [7:0]       zk_prime_out_r;
    logic [11:0]      tail_r;
    logic             tail_valid_r;
    logic             tail_err_r;
    logic             proto_err_r;

    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] nbeats_sel_s;

    assign cnt_inc_s    = cnt_r + CNT_ONE;
    assign nbeats_sel_s = blk_size_sel ? NB_LARGE : NB_SMALL;

    // Block FSM: consumes valid beats, forwards data, unpacks the tail beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            nbeats_r       <= CNT_ZERO;
            out_valid_r    <= 1'b0;
            out_sop_r      <= 1'b0;
            out_eop_r      <= 1'b0;
            xk_out_r       <= 8'h00;
            zk_out_r       <= 8'h00;
            zk_prime_out_r <= 8'h00;
            tail_r         <= 12'h000;
            tail_valid_r   <= 1'b0;
            tail_err_r     <= 1'b0;
            proto_err_r    <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            out_sop_r    <= 1'b0;
            out_eop_r    <= 1'b0;
            tail_valid_r <= 1'b0;
            tail_err_r   <= 1'b0;
            proto_err_r  <= 1'b0;
            if (in_valid && in_sop) begin
                // A sop always opens a block; outside IDLE it also aborts the one in flight.
                proto_err_r    <= (state_r != ST_IDLE);
                nbeats_r       <= nbeats_sel_s;
                cnt_r          <= CNT_ONE;
                out_valid_r    <= 1'b1;
                out_sop_r      <= 1'b1;
                xk_out_r       <= xk_in;
                zk_out_r       <= zk_in;
                zk_prime_out_r <= zk_prime_in;
                state_r        <= ST_DATA;
            end else if (in_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        proto_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                    ST_DATA: begin
                        out_valid_r    <= 1'b1;
                        xk_out_r       <= xk_in;
                        zk_out_r       <= zk_in;
                        zk_prime_out_r <= zk_prime_in;
                        cnt_r          <= cnt_inc_s;
                        if (cnt_inc_s == nbeats_r) begin
                            out_eop_r <= 1'b1;
                            state_r   <= ST_TAIL;
                        end else begin
                            state_r   <= ST_DATA;
                        end
                    end
                    ST_TAIL: begin
                        tail_r       <= unpack_tail(xk_in[3:0], zk_in[3:0], zk_prime_in[3:0]);
                        tail_valid_r <= 1'b1;
                        tail_err_r   <= tail_nibble_err(xk_in[7:4], zk_in[7:4], zk_prime_in[7:4]);
                        cnt_r        <= CNT_ZERO;
                        state_r      <= ST_IDLE;
                    end
                    default: begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign out_valid    = out_valid_r;
    assign out_sop      = out_sop_r;
    assign out_eop      = out_eop_r;
    assign xk_out       = xk_out_r;
    assign zk_out       = zk_out_r;
    assign zk_prime_out = zk_prime_out_r;
    assign tail_x1      = tail_r[11:9];
    assign tail_z1      = tail_r[8:6];
    assign tail_x2      = tail_r[5:3];
    assign tail_z2      = tail_r[2:0];
    assign tail_valid   = tail_valid_r;
    assign tail_err     = tail_err_r;
    assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_tail_bits_extractor_parallel.sv
// Self-checking bench for tail_bits_extractor_parallel: a beat-level reference
// model compared every cycle, a table of tail-beat vectors with hand-derived
// unpacked values, and directed sequences for abort, reset and back-to-back blocks.
module tb_tail_bits_extractor_parallel;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_sop;
    logic       blk_size_sel;
    logic [7:0] xk_in;
    logic [7:0] zk_in;
    logic [7:0] zk_prime_in;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic [7:0] xk_out;
    logic [7:0] zk_out;
    logic [7:0] zk_prime_out;
    logic [2:0] tail_x1;
    logic [2:0] tail_z1;
    logic [2:0] tail_x2;
    logic [2:0] tail_z2;
    logic       tail_valid;
    logic       tail_err;
    logic       proto_err;

    always #5 clock = ~clock;

    tail_bits_extractor_parallel dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .blk_size_sel (blk_size_sel),
        .xk_in        (xk_in),
        .zk_in        (zk_in),
        .zk_prime_in  (zk_prime_in),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .xk_out       (xk_out),
        .zk_out       (zk_out),
        .zk_prime_out (zk_prime_out),
        .tail_x1      (tail_x1),
        .tail_z1      (tail_z1),
        .tail_x2      (tail_x2),
        .tail_z2      (tail_z2),
        .tail_valid   (tail_valid),
        .tail_err     (tail_err),
        .proto_err    (proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: position within the block in consumed beats.
    int m_pos = 0;
    int m_nb  = 0;
    localparam int NB_SMALL = 1056 / 8;
    localparam int NB_LARGE = 6144 / 8;

    logic       e_ov, e_os, e_oe, e_tv, e_te, e_pe;
    logic [7:0] e_x, e_z, e_zp;
    logic [11:0] e_t;

    // Event counters observed on the DUT outputs.
    int c_fwd, c_eop, c_tail, c_proto, c_cons, eop_at, tail_at;

    typedef struct {
        logic [7:0] x;
        logic [7:0] z;
        logic [7:0] zp;
        logic [2:0] ex1;
        logic [2:0] ez1;
        logic [2:0] ex2;
        logic [2:0] ez2;
        logic       eerr;
    } tail_vec_t;

    tail_vec_t tv [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Each lane pair gives one encoder's termination: x1/z1 from bits 0-1, x2/z2 from bits 2-3.
    function automatic logic [11:0] ref_tail(input logic [7:0] x, input logic [7:0] z, input logic [7:0] zp);
        logic [2:0] x1, z1, x2, z2;
        x1[0] = x[0];  x1[1] = zp[0]; x1[2] = z[1];
        z1[0] = z[0];  z1[1] = x[1];  z1[2] = zp[1];
        x2[0] = x[2];  x2[1] = zp[2]; x2[2] = z[3];
        z2[0] = z[2];  z2[1] = x[3];  z2[2] = zp[3];
        return {x1, z1, x2, z2};
    endfunction

    task automatic model_step(input logic r, input logic v, input logic s, input logic sel,
                              input logic [7:0] x, input logic [7:0] z, input logic [7:0] zp);
        if (!r) begin
            {e_ov, e_os, e_oe, e_tv, e_te, e_pe} = 6'b0;
            e_x = 8'h00; e_z = 8'h00; e_zp = 8'h00; e_t = 12'h000;
            m_pos = 0; m_nb = 0;
        end else begin
            {e_ov, e_os, e_oe, e_tv, e_te, e_pe} = 6'b0;
            if (v && s) begin
                e_pe = (m_pos != 0);
                m_nb = sel ? NB_LARGE : NB_SMALL;
                m_pos = 1;
                e_ov = 1'b1; e_os = 1'b1;
                e_x = x; e_z = z; e_zp = zp;
            end else if (v && m_pos == 0) begin
                e_pe = 1'b1;
            end else if (v && m_pos < m_nb) begin
                m_pos++;
                e_ov = 1'b1;
                e_oe = (m_pos == m_nb);
                e_x = x; e_z = z; e_zp = zp;
            end else if (v) begin
                e_tv = 1'b1;
                e_te = ((x >> 4) | (z >> 4) | (zp >> 4)) != 8'h00;
                e_t = ref_tail(x, z, zp);
                m_pos = 0;
            end
        end
    endtask

    task automatic clear_counts();
        c_fwd = 0; c_eop = 0; c_tail = 0; c_proto = 0; c_cons = 0; eop_at = -1; tail_at = -1;
    endtask

    task automatic cycle(input logic r, input logic v, input logic s, input logic sel,
                         input logic [7:0] x, input logic [7:0] z, input logic [7:0] zp);
        reset = r; in_valid = v; in_sop = s; blk_size_sel = sel;
        xk_in = x; zk_in = z; zk_prime_in = zp;
        model_step(r, v, s, sel, x, z, zp);
        if (r && v) c_cons++;
        @(posedge clock);
        #1;
        cyc++;
        check($sformatf("cycle%0d_outputs", cyc),
              64'({out_valid, out_sop, out_eop, xk_out, zk_out, zk_prime_out,
                   tail_x1, tail_z1, tail_x2, tail_z2, tail_valid, tail_err, proto_err}),
              64'({e_ov, e_os, e_oe, e_x, e_z, e_zp, e_t, e_tv, e_te, e_pe}));
        if (out_valid) c_fwd++;
        if (out_eop) begin c_eop++; eop_at = c_fwd; end
        if (tail_valid) begin c_tail++; tail_at = c_cons; end
        if (proto_err) c_proto++;
    endtask

    task automatic beat(input logic s, input logic sel, input logic [7:0] x, input logic [7:0] z, input logic [7:0] zp);
        cycle(1'b1, 1'b1, s, sel, x, z, zp);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Sends sop + data beats (x = beat index) and a tail beat, optionally with random gaps.
    task automatic run_block(input logic sel, input logic [7:0] tx, input logic [7:0] tz,
                             input logic [7:0] tzp, input bit gaps);
        int nb;
        logic [7:0] b;
        nb = sel ? NB_LARGE : NB_SMALL;
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3; g++) if ($urandom_range(0, 3) == 0) idle();
            end
            b = 8'(i);
            beat(i == 0, sel, b, ~b, b ^ 8'h5A);
        end
        if (gaps) idle();
        beat(1'b0, sel, tx, tz, tzp);
    endtask

    initial begin
        tv[0] = '{8'h05, 8'h0A, 8'h03, 3'b111, 3'b100, 3'b101, 3'b000, 1'b0};
        tv[1] = '{8'h10, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
        tv[2] = '{8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tv[3] = '{8'h0F, 8'h0F, 8'h0F, 3'b111, 3'b111, 3'b111, 3'b111, 1'b0};
        tv[4] = '{8'h01, 8'h00, 8'h00, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
        tv[5] = '{8'h00, 8'h02, 8'h00, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0};
        tv[6] = '{8'h00, 8'h00, 8'hF4, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1};
        tv[7] = '{8'h08, 8'h04, 8'h00, 3'b000, 3'b000, 3'b000, 3'b011, 1'b0};

        // Reset state
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("reset_outputs",
              64'({out_valid, out_sop, out_eop, xk_out, zk_out, zk_prime_out,
                   tail_x1, tail_z1, tail_x2, tail_z2, tail_valid, tail_err, proto_err}), 64'd0);

        // K=1056 block with the reference tail
        clear_counts();
        run_block(1'b0, 8'h05, 8'h0A, 8'h03, 1'b0);
        check("k1056_fwd_count", 64'(c_fwd), 64'd132);
        check("k1056_eop_pos", 64'(eop_at), 64'd132);
        check("k1056_tail_valid", 64'(tail_valid), 64'd1);
        check("k1056_tails", 64'({tail_x1, tail_z1, tail_x2, tail_z2, tail_err}), 64'({3'b111, 3'b100, 3'b101, 3'b000, 1'b0}));
        idle();
        check("tail_hold", 64'({tail_x1, tail_z1, tail_x2, tail_z2, tail_valid}), 64'({3'b111, 3'b100, 3'b101, 3'b000, 1'b0}));

        // K=6144 with random gaps
        clear_counts();
        run_block(1'b1, 8'h0C, 8'h03, 8'h05, 1'b1);
        check("k6144_fwd_count", 64'(c_fwd), 64'd768);
        check("k6144_eop_pos", 64'(eop_at), 64'd768);
        check("k6144_tail_at", 64'(tail_at), 64'd769);
        check("k6144_tail_count", 64'(c_tail), 64'd1);

        // Tail-vector table, blocks back-to-back
        for (int i = 0; i < 8; i++) begin
            run_block(1'b0, tv[i].x, tv[i].z, tv[i].zp, 1'b0);
            check($sformatf("table%0d_tail", i),
                  64'({tail_valid, tail_x1, tail_z1, tail_x2, tail_z2, tail_err}),
                  64'({1'b1, tv[i].ex1, tv[i].ez1, tv[i].ex2, tv[i].ez2, tv[i].eerr}));
        end

        // Abort: sop at beat 50, then a full block
        clear_counts();
        for (int i = 0; i < 50; i++) beat(i == 0, 1'b0, 8'(i), 8'h11, 8'h22);
        run_block(1'b0, 8'h05, 8'h0A, 8'h03, 1'b0);
        check("abort_proto", 64'(c_proto), 64'd1);
        check("abort_eop", 64'(c_eop), 64'd1);
        check("abort_tail", 64'(c_tail), 64'd1);
        check("abort_fwd", 64'(c_fwd), 64'd182);

        // Reset mid-DATA, then a non-sop beat
        for (int i = 0; i < 20; i++) beat(i == 0, 1'b0, 8'(i), 8'h33, 8'h44);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 8'h77);
        check("midreset_outputs",
              64'({out_valid, out_sop, out_eop, xk_out, zk_out, zk_prime_out,
                   tail_x1, tail_z1, tail_x2, tail_z2, tail_valid, tail_err, proto_err}), 64'd0);
        beat(1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        check("midreset_proto", 64'({proto_err, out_valid}), 64'({1'b1, 1'b0}));

        // Two back-to-back blocks
        clear_counts();
        run_block(1'b0, 8'h01, 8'h02, 8'h04, 1'b0);
        run_block(1'b0, 8'h08, 8'h04, 8'h02, 1'b0);
        check("b2b_fwd", 64'(c_fwd), 64'd264);
        check("b2b_tails", 64'(c_tail), 64'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            cycle(1'($urandom_range(0, 499) != 0),
                  1'($urandom_range(0, 2) != 0),
                  (m_pos == 0) ? 1'($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 7) == 0),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
